// File: rtl/axi_read_arbiter_pkg.sv
// Shared AXI read types, width constants and the arbiter state encoding.
// Imported by the read interface and by the two-master read arbiter.
package axi_read_arbiter_pkg;

    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int AXI_ARLEN_WIDTH = 8;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        AXI_SIZE_1B   = 3'd0,
        AXI_SIZE_2B   = 3'd1,
        AXI_SIZE_4B   = 3'd2,
        AXI_SIZE_8B   = 3'd3,
        AXI_SIZE_16B  = 3'd4,
        AXI_SIZE_32B  = 3'd5,
        AXI_SIZE_64B  = 3'd6,
        AXI_SIZE_128B = 3'd7
    } axi_size_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axi_read_if.sv
// AXI read-only channel bundle (AR + R) with master and slave views.
interface axi_read_if;
    import axi_read_arbiter_pkg::*;

    logic [ADDR_WIDTH-1:0]      araddr;
    logic [AXI_ARLEN_WIDTH-1:0] arlen;
    axi_size_t                  arsize;
    axi_burst_type_t            arburst;
    logic                       arvalid;
    logic                       arready;
    logic [DATA_WIDTH-1:0]      rdata;
    axi_resp_t                  rresp;
    logic                       rlast;
    logic                       rvalid;
    logic                       rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_read_arbiter.sv
// Shares one memory AXI read port between icache and dcache refill engines,
// one burst at a time, with a beat-count sanity check on the R channel.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    axi_read_if.slave  icache_axi,
    axi_read_if.slave  dcache_axi,
    axi_read_if.master mem_axi,
    output logic       grant_dcache,
    output logic       busy,
    output logic       len_err
);

    arb_state_t                 state_q;
    logic                       grant_dcache_q;
    logic [AXI_ARLEN_WIDTH-1:0] len_q;
    logic [AXI_ARLEN_WIDTH:0]   beat_cnt_q;
    logic                       len_err_q;

    logic pick_dcache;
    logic ar_hs;
    logic r_hs;
    logic beat_is_len;

    // grant_dcache_q doubles as "last owner" for the round-robin tie-break
    always_comb begin
        pick_dcache = dcache_axi.arvalid;
        if (icache_axi.arvalid && dcache_axi.arvalid) begin
            pick_dcache = ROUND_ROBIN ? !grant_dcache_q : 1'b1;
        end
    end

    assign ar_hs       = mem_axi.arvalid && mem_axi.arready;
    assign r_hs        = mem_axi.rvalid && mem_axi.rready;
    assign beat_is_len = (beat_cnt_q == {1'b0, len_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            grant_dcache_q <= 1'b0;
            len_q          <= '0;
            beat_cnt_q     <= '0;
            len_err_q      <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (icache_axi.arvalid || dcache_axi.arvalid) begin
                        grant_dcache_q <= pick_dcache;
                        state_q        <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        len_q      <= mem_axi.arlen;
                        beat_cnt_q <= '0;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (mem_axi.rlast) begin
                            len_err_q <= !beat_is_len;
                            state_q   <= IDLE;
                        end else begin
                            len_err_q <= beat_is_len;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_axi.araddr     = '0;
        mem_axi.arlen      = '0;
        mem_axi.arsize     = AXI_SIZE_1B;
        mem_axi.arburst    = AXI_BURST_FIXED;
        mem_axi.arvalid    = 1'b0;
        mem_axi.rready     = 1'b0;
        icache_axi.arready = 1'b0;
        icache_axi.rvalid  = 1'b0;
        icache_axi.rlast   = 1'b0;
        icache_axi.rdata   = '0;
        icache_axi.rresp   = AXI_RESP_OKAY;
        dcache_axi.arready = 1'b0;
        dcache_axi.rvalid  = 1'b0;
        dcache_axi.rlast   = 1'b0;
        dcache_axi.rdata   = '0;
        dcache_axi.rresp   = AXI_RESP_OKAY;
        case (state_q)
            ADDR: begin
                if (grant_dcache_q) begin
                    mem_axi.araddr     = dcache_axi.araddr;
                    mem_axi.arlen      = dcache_axi.arlen;
                    mem_axi.arsize     = dcache_axi.arsize;
                    mem_axi.arburst    = dcache_axi.arburst;
                    mem_axi.arvalid    = dcache_axi.arvalid;
                    dcache_axi.arready = mem_axi.arready;
                end else begin
                    mem_axi.araddr     = icache_axi.araddr;
                    mem_axi.arlen      = icache_axi.arlen;
                    mem_axi.arsize     = icache_axi.arsize;
                    mem_axi.arburst    = icache_axi.arburst;
                    mem_axi.arvalid    = icache_axi.arvalid;
                    icache_axi.arready = mem_axi.arready;
                end
            end
            DATA: begin
                if (grant_dcache_q) begin
                    dcache_axi.rvalid = mem_axi.rvalid;
                    dcache_axi.rlast  = mem_axi.rlast;
                    dcache_axi.rdata  = mem_axi.rdata;
                    dcache_axi.rresp  = mem_axi.rresp;
                    mem_axi.rready    = dcache_axi.rready;
                end else begin
                    icache_axi.rvalid = mem_axi.rvalid;
                    icache_axi.rlast  = mem_axi.rlast;
                    icache_axi.rdata  = mem_axi.rdata;
                    icache_axi.rresp  = mem_axi.rresp;
                    mem_axi.rready    = icache_axi.rready;
                end
            end
            default: ;
        endcase
    end

    assign grant_dcache = grant_dcache_q;
    assign busy         = (state_q == ADDR) || (state_q == DATA);
    assign len_err      = len_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a round-robin and a fixed-priority
// instance share stimulus; sel_fp picks which one is observed.
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    typedef struct packed {
        logic        mem_arvalid;
        logic [31:0] mem_araddr;
        logic [7:0]  mem_arlen;
        logic        mem_rready;
        logic        ic_arready;
        logic        ic_rvalid;
        logic        ic_rlast;
        logic [31:0] ic_rdata;
        logic [1:0]  ic_rresp;
        logic        dc_arready;
        logic        dc_rvalid;
        logic        dc_rlast;
        logic [31:0] dc_rdata;
        logic [1:0]  dc_rresp;
        logic        grant;
        logic        busy;
        logic        len_err;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]     ic_araddr = '0, dc_araddr = '0;
    logic [7:0]      ic_arlen = '0, dc_arlen = '0;
    axi_size_t       ar_size = AXI_SIZE_4B;
    axi_burst_type_t ar_burst = AXI_BURST_INCR;
    logic            ic_arvalid = 1'b0, dc_arvalid = 1'b0;
    logic            ic_rready = 1'b1, dc_rready = 1'b1;
    logic            mem_arready = 1'b0, mem_rvalid = 1'b0, mem_rlast = 1'b0;
    logic [31:0]     mem_rdata = '0;
    axi_resp_t       mem_rresp = AXI_RESP_OKAY;

    obs_t obs [2];
    logic sel_fp = 1'b0;
    obs_t o;
    assign o = obs[sel_fp];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            axi_read_if ic_if ();
            axi_read_if dc_if ();
            axi_read_if mem_if ();
            logic grant_w, busy_w, len_err_w;

            assign ic_if.araddr   = ic_araddr;
            assign ic_if.arlen    = ic_arlen;
            assign ic_if.arsize   = ar_size;
            assign ic_if.arburst  = ar_burst;
            assign ic_if.arvalid  = ic_arvalid;
            assign ic_if.rready   = ic_rready;
            assign dc_if.araddr   = dc_araddr;
            assign dc_if.arlen    = dc_arlen;
            assign dc_if.arsize   = ar_size;
            assign dc_if.arburst  = ar_burst;
            assign dc_if.arvalid  = dc_arvalid;
            assign dc_if.rready   = dc_rready;
            assign mem_if.arready = mem_arready;
            assign mem_if.rdata   = mem_rdata;
            assign mem_if.rresp   = mem_rresp;
            assign mem_if.rlast   = mem_rlast;
            assign mem_if.rvalid  = mem_rvalid;

            axi_read_arbiter #(.ROUND_ROBIN((gi == 0) ? 1'b1 : 1'b0)) u_dut (
                .clk          (clk),
                .rst          (rst),
                .icache_axi   (ic_if),
                .dcache_axi   (dc_if),
                .mem_axi      (mem_if),
                .grant_dcache (grant_w),
                .busy         (busy_w),
                .len_err      (len_err_w)
            );

            assign obs[gi] = '{mem_arvalid: mem_if.arvalid, mem_araddr: mem_if.araddr,
                               mem_arlen: mem_if.arlen, mem_rready: mem_if.rready,
                               ic_arready: ic_if.arready, ic_rvalid: ic_if.rvalid,
                               ic_rlast: ic_if.rlast, ic_rdata: ic_if.rdata, ic_rresp: ic_if.rresp,
                               dc_arready: dc_if.arready, dc_rvalid: dc_if.rvalid,
                               dc_rlast: dc_if.rlast, dc_rdata: dc_if.rdata, dc_rresp: dc_if.rresp,
                               grant: grant_w, busy: busy_w, len_err: len_err_w};
        end
    endgenerate

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // beats delivered to each master and len_err high cycles
    logic [31:0] ic_q[$];
    logic [31:0] dc_q[$];
    int len_err_cnt = 0;
    always @(posedge clk) begin
        if (o.ic_rvalid && ic_rready) ic_q.push_back(o.ic_rdata);
        if (o.dc_rvalid && dc_rready) dc_q.push_back(o.dc_rdata);
        if (o.len_err) len_err_cnt++;
    end

    // Memory responder: accepts one AR, returns nbeats beats (data = addr+beat),
    // rlast on beat index last_at.
    task automatic mem_serve(input string tag, input int ar_delay, input int nbeats,
                             input int last_at, input int stall_beat, input int late_beat,
                             input bit keep_req, output logic owner, output logic [31:0] addr);
        int wait_cnt;
        int stall;
        logic [7:0] len;
        wait_cnt = 0;
        do begin
            @(negedge clk); #1;
            wait_cnt++;
        end while (!o.mem_arvalid && wait_cnt < 20);
        check_val({tag, "_ar_seen"}, {31'd0, o.mem_arvalid}, 32'd1);
        addr = o.mem_araddr;
        len  = o.mem_arlen;
        for (int i = 0; i < ar_delay; i++) begin
            @(negedge clk); #1;
            check_val({tag, "_araddr_stable"}, o.mem_araddr, addr);
            check_val({tag, "_arlen_stable"}, {24'd0, o.mem_arlen}, {24'd0, len});
        end
        @(negedge clk);
        mem_arready = 1'b1;
        #1;
        owner = o.grant;
        @(negedge clk);
        mem_arready = 1'b0;
        if (!keep_req) begin
            if (owner) dc_arvalid = 1'b0;
            else       ic_arvalid = 1'b0;
        end
        for (int b = 0; b < nbeats; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = addr + b;
            mem_rlast  = (b == last_at);
            if (b == late_beat) dc_arvalid = 1'b1;
            stall    = (b == stall_beat) ? 2 : 0;
            wait_cnt = 0;
            while (1) begin
                if (stall > 0) begin
                    ic_rready = 1'b0;
                    dc_rready = 1'b0;
                    stall--;
                end else begin
                    ic_rready = 1'b1;
                    dc_rready = 1'b1;
                end
                #1;
                check_val({tag, "_ungranted_rvalid"},
                          {31'd0, owner ? o.ic_rvalid : o.dc_rvalid}, 32'd0);
                if (late_beat >= 0 && b >= late_beat)
                    check_val({tag, "_late_dc_arready"}, {31'd0, o.dc_arready}, 32'd0);
                if (o.mem_rready || wait_cnt > 10) break;
                wait_cnt++;
                @(negedge clk);
            end
            check_val({tag, "_r_hs"}, {31'd0, o.mem_rready}, 32'd1);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
    endtask

    task automatic check_beats(input string tag, input bit dc, input logic [31:0] base, input int n);
        if (dc) begin
            check_val({tag, "_dc_beats"}, dc_q.size(), n);
            for (int i = 0; i < n && i < dc_q.size(); i++)
                check_val({tag, "_dc_data"}, dc_q[i], base + i);
        end else begin
            check_val({tag, "_ic_beats"}, ic_q.size(), n);
            for (int i = 0; i < n && i < ic_q.size(); i++)
                check_val({tag, "_ic_data"}, ic_q[i], base + i);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic        own;
    logic [31:0] addr;
    logic        exp_own[4];
    int          err_base;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        // reset values
        check_val("rst_busy", {31'd0, o.busy}, 32'd0);
        check_val("rst_grant", {31'd0, o.grant}, 32'd0);
        check_val("rst_len_err", {31'd0, o.len_err}, 32'd0);
        check_val("rst_mem_arvalid", {31'd0, o.mem_arvalid}, 32'd0);
        check_val("rst_mem_araddr", o.mem_araddr, 32'd0);
        check_val("rst_mem_rready", {31'd0, o.mem_rready}, 32'd0);

        // single icache burst
        @(negedge clk);
        ic_araddr = 32'h100; ic_arlen = 8'd3; ic_arvalid = 1'b1;
        #1;
        check_val("t1_bubble", {31'd0, o.mem_arvalid}, 32'd0);
        @(negedge clk); #1;
        check_val("t1_arvalid_n1", {31'd0, o.mem_arvalid}, 32'd1);
        check_val("t1_araddr_n1", o.mem_araddr, 32'h100);
        ic_q.delete(); dc_q.delete();
        mem_serve("t1", 0, 4, 3, -1, -1, 1'b0, own, addr);
        #1;
        check_val("t1_owner", {31'd0, own}, 32'd0);
        check_val("t1_idle", {31'd0, o.busy}, 32'd0);
        check_val("t1_len_err", {31'd0, o.len_err}, 32'd0);
        check_beats("t1", 1'b0, 32'h100, 4);
        check_val("t1_dc_none", dc_q.size(), 32'd0);
        check_val("t1_err_cnt", len_err_cnt, 32'd0);

        // round-robin tie: dcache first after reset
        exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
        ic_araddr = 32'h110; ic_arlen = 8'd1; ic_arvalid = 1'b1;
        dc_araddr = 32'h210; dc_arlen = 8'd1; dc_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_serve("rr", 0, 2, 1, -1, -1, 1'b1, own, addr);
            check_val("rr_owner", {31'd0, own}, {31'd0, exp_own[i]});
            check_val("rr_addr", addr, exp_own[i] ? 32'h210 : 32'h110);
        end
        ic_arvalid = 1'b0; dc_arvalid = 1'b0;
        repeat (3) @(negedge clk);

        // backpressure: arready delayed 3 cycles, icache stalls rready on beat 2
        ic_q.delete();
        ic_araddr = 32'h500; ic_arlen = 8'd3; ic_arvalid = 1'b1;
        mem_serve("bp", 3, 4, 3, 1, -1, 1'b0, own, addr);
        check_beats("bp", 1'b0, 32'h500, 4);

        // late dcache request during icache beat 2
        ic_q.delete(); dc_q.delete();
        ic_araddr = 32'h600; ic_arlen = 8'd3; ic_arvalid = 1'b1;
        dc_araddr = 32'h700; dc_arlen = 8'd0;
        mem_serve("late", 0, 4, 3, -1, 1, 1'b0, own, addr);
        #1;
        check_val("late_idle_busy", {31'd0, o.busy}, 32'd0);
        check_val("late_idle_arvalid", {31'd0, o.mem_arvalid}, 32'd0);
        @(negedge clk); #1;
        check_val("late_n2_arvalid", {31'd0, o.mem_arvalid}, 32'd1);
        check_val("late_n2_araddr", o.mem_araddr, 32'h700);
        mem_serve("late_dc", 0, 1, 0, -1, -1, 1'b0, own, addr);
        check_val("late_dc_owner", {31'd0, own}, 32'd1);
        check_beats("late", 1'b1, 32'h700, 1);
        check_beats("late_ic", 1'b0, 32'h600, 4);

        // arlen=3 with early rlast on beat 2
        err_base = len_err_cnt;
        ic_araddr = 32'h800; ic_arlen = 8'd3; ic_arvalid = 1'b1;
        mem_serve("len_short", 0, 2, 1, -1, -1, 1'b0, own, addr);
        #1;
        check_val("len_short_pulse", {31'd0, o.len_err}, 32'd1);
        check_val("len_short_idle", {31'd0, o.busy}, 32'd0);
        @(negedge clk); #1;
        check_val("len_short_drop", {31'd0, o.len_err}, 32'd0);
        check_val("len_short_cnt", len_err_cnt - err_base, 32'd1);

        // arlen=1 with no rlast on beat 2 (rlast on beat 3 is also late)
        err_base = len_err_cnt;
        ic_araddr = 32'h900; ic_arlen = 8'd1; ic_arvalid = 1'b1;
        mem_serve("len_long", 0, 3, 2, -1, -1, 1'b0, own, addr);
        @(negedge clk); #1;
        check_val("len_long_cnt", len_err_cnt - err_base, 32'd2);

        // reset in DATA after beat 1
        ic_q.delete();
        @(negedge clk);
        ic_araddr = 32'hA00; ic_arlen = 8'd3; ic_arvalid = 1'b1;
        repeat (2) @(negedge clk);
        mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0; ic_arvalid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hA00; mem_rlast = 1'b0;
        @(negedge clk);
        mem_rdata = 32'hA01;
        rst = 1'b1;
        @(negedge clk); #1;
        check_val("rst_data_busy", {31'd0, o.busy}, 32'd0);
        check_val("rst_data_rready", {31'd0, o.mem_rready}, 32'd0);
        check_val("rst_data_ic_rvalid", {31'd0, o.ic_rvalid}, 32'd0);
        check_val("rst_data_dc_rvalid", {31'd0, o.dc_rvalid}, 32'd0);
        check_val("rst_data_ic_arready", {31'd0, o.ic_arready}, 32'd0);
        check_val("rst_data_dc_arready", {31'd0, o.dc_arready}, 32'd0);
        check_val("rst_data_ic_rdata", o.ic_rdata, 32'd0);
        rst = 1'b0; mem_rvalid = 1'b0;
        ic_q.delete();
        ic_araddr = 32'hB00; ic_arlen = 8'd1; ic_arvalid = 1'b1;
        mem_serve("post_rst", 0, 2, 1, -1, -1, 1'b0, own, addr);
        check_val("post_rst_addr", addr, 32'hB00);
        check_beats("post_rst", 1'b0, 32'hB00, 2);

        // fixed priority instance: dcache wins every tie
        @(negedge clk);
        rst = 1'b1; sel_fp = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ic_araddr = 32'h110; ic_arlen = 8'd1; ic_arvalid = 1'b1;
        dc_araddr = 32'h210; dc_arlen = 8'd1; dc_arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_serve("fp", 0, 2, 1, -1, -1, 1'b1, own, addr);
            check_val("fp_owner", {31'd0, own}, 32'd1);
            check_val("fp_addr", addr, 32'h210);
        end
        dc_arvalid = 1'b0;
        mem_serve("fp_ic", 0, 2, 1, -1, -1, 1'b0, own, addr);
        check_val("fp_ic_owner", {31'd0, own}, 32'd0);
        check_val("fp_ic_addr", addr, 32'h110);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Two-master, one-slave AXI read arbiter sharing the single memory read port between the instruction cache and the data cache refill engines. It grants one read burst at a time, forwards that master's AR channel to memory, routes the R beats back until `rlast`, then re-arbitrates. It sits between the two cache `axi_read_if` master ports and the memory-side `axi_read_if` slave.

## Interface
- `ROUND_ROBIN`, default 1: 1 = alternate grant on a tie; 0 = fixed priority, dcache wins ties.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `icache_axi`  `axi_read_if.slave`  —  icache refill requester.
- `dcache_axi`  `axi_read_if.slave`  —  dcache refill requester.
- `mem_axi`  `axi_read_if.master`  —  shared memory read port.
- `grant_dcache`  out  1  owner of the current or last burst (1 = dcache).
- `busy`  out  1  high in ADDR and DATA.
- `len_err`  out  1  one-cycle pulse on a beat-count mismatch.
- Interface field widths are `ADDR_WIDTH`, `DATA_WIDTH`, `AXI_ARLEN_WIDTH`, and the enum types from `_riscv_defines`.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE
  - If no requester has `arvalid` high, stay in IDLE.
  - If exactly one requester has `arvalid` high, grant it.
  - If both are high and `ROUND_ROBIN`=1, grant the master not granted last. If `ROUND_ROBIN`=0, grant dcache.
  - On a grant, register `grant_dcache` and go to ADDR.
- ADDR
  - Drive `mem_axi.araddr/arlen/arsize/arburst/arvalid` from the granted master's AR fields.
  - Connect `mem_axi.arready` to the granted master's `arready`.
  - On handshake (`mem_axi.arvalid && arready`): latch `arlen` into `len_q`, clear `beat_cnt`, go to DATA.
- DATA
  - Route `mem_axi.rdata/rresp/rlast/rvalid` to the granted master. Drive `mem_axi.rready` from the granted master's `rready`.
  - Increment `beat_cnt` on each R handshake (width `AXI_ARLEN_WIDTH`+1).
  - On an R handshake with `rlast`=1, go to IDLE.
  - Pulse `len_err` on a mismatch: `rlast` arrives with `beat_cnt != len_q`, or beat number `len_q`+1 arrives without `rlast`.
  - Forward `rlast` unchanged; the beat counter never alters routing.
- Ungranted master: `arready`, `rvalid`, `rlast` = 0; `rdata` = 0; `rresp` = OKAY.
- Memory AR outputs are all-zero with `arvalid`=0 outside ADDR. `mem_axi.rready`=0 outside DATA.
- Granted master dropping `arvalid` in ADDR is a protocol violation. The FSM stays in ADDR and forwards `arvalid`=0; it does not re-arbitrate.

## Timing
- Reset: state=IDLE, `grant_dcache`=0, `busy`=0, `len_err`=0, `beat_cnt`=0, `len_q`=0.
  - With last grant = icache, the first round-robin tie goes to dcache.
  - All interface outputs take their idle values above. Reset in ADDR or DATA abandons the burst immediately.
- Grant latency: `arvalid` seen in IDLE at cycle N → `mem_axi.arvalid` high at N+1. One bubble cycle per arbitration.
- AR and R paths are combinational pass-through once granted; no added latency per beat.
- The final R handshake at cycle N puts the FSM in IDLE at N+1. The next ADDR is N+2 at the earliest.
- A requester raising `arvalid` mid-burst waits; its `arready` stays 0 until granted.
- `len_err` is registered: it is high the cycle after the offending beat, for exactly one cycle.

## Structure
- Add `arb_state_t` (IDLE/ADDR/DATA) enum to `_riscv_defines`.
- Reuse `axi_resp_t`, `axi_size_t`, `axi_burst_type_t` and the width constants from that package.
- Single module; no sub-module. The routing mux is an `always_comb` keyed on state and `grant_dcache`.

## Test plan
- Single icache burst: `araddr`=0x100, `arlen`=3, memory returns 4 beats, `rlast` on beat 4.
  - `mem_axi.araddr`=0x100 one cycle after request.
  - icache receives 4 beats and dcache none.
  - FSM is IDLE after the `rlast` cycle; `len_err` stays 0.
- Simultaneous requests, `ROUND_ROBIN`=1, each master holding a `arlen`=1 request high:
  - Bursts are served dcache, icache, dcache, icache.
  - With `ROUND_ROBIN`=0, dcache is served every time it requests.
- Backpressure: memory holds `arready`=0 for 3 cycles, and icache drops `rready` mid-burst.
  - AR fields stay stable throughout; no beat is lost or duplicated; `rdata` order is preserved.
- Mid-burst late request: dcache asserts `arvalid` during icache beat 2.
  - dcache `arready` stays 0 until icache `rlast`; dcache's AR appears on memory 2 cycles after that last handshake.
- Length checking:
  - `arlen`=3 with `rlast` on beat 2 → `len_err` pulses once; FSM returns to IDLE.
  - `arlen`=1 with no `rlast` on beat 2 → `len_err` pulse.
- Reset in DATA after beat 1 → next cycle: IDLE, `mem_axi.rready`=0, all `arready`/`rvalid`=0. A new request is then served normally.
